branch_resolve_predict: RTL
===========================

# branch_resolve_predict

Parametrised branch resolution unit with an integrated 2-bit direction predictor. It replaces the purely combinational branch comparator in the EX stage. It evaluates all conditional-branch opcodes, including REGIMM BGEZ, at a configurable data width, and registers the outcome. It also trains a bimodal history table that the ID stage reads for taken/not-taken prediction, and raises a registered mispredict flag for pipeline flush.

## Interface
- DATA_W, 32, operand width; signed compare
- PC_W, 32, program-counter width
- BHT_DEPTH, 64, number of 2-bit counters; power of two, ≥4; IDX_W = log2(BHT_DEPTH)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_pc  in  PC_W  PC of the instruction in ID (lookup)
- id_pred_taken  out  1  predicted direction for id_pc, combinational
- ex_valid  in  1  EX-stage instruction valid
- ex_flush  in  1  EX instruction is being squashed; suppresses resolve and update
- ex_pc  in  PC_W  PC of the EX instruction
- ex_opcode  in  6  primary opcode
- ex_rt  in  5  rt field, REGIMM sub-op select
- ex_arg1  in  DATA_W  rs operand (forwarded)
- ex_arg2  in  DATA_W  rt operand, or zero for BLEZ/BGTZ/REGIMM (datapath supplies)
- ex_pred_taken  in  1  prediction carried down the pipe from ID
- res_valid  out  1  registered: a branch resolved last cycle
- res_taken  out  1  registered: actual direction
- mispredict  out  1  registered: res_valid & (res_taken != carried prediction)

## Operation
- Branch decode (is_br): 6'h04 BEQ eq; 6'h05 BNE ne; 6'h06 BLEZ le; 6'h07 BGTZ gt; 6'h01 with rt=0 BLTZ lt, rt=1 BGEZ ge. Anything else, including 6'h01 with other rt: not a branch.
- Compare: two's-complement signed over DATA_W. lt = signed(arg1) < signed(arg2); gt symmetric; le = !gt; ge = !lt; ne = !eq.
- Index: idx = pc[IDX_W+1:2], for both lookup and update.
- Lookup: id_pred_taken = bht[idx(id_pc)][1], combinational.
- Update, when ex_valid & !ex_flush & is_br: the counter at idx(ex_pc) saturates. Taken increments to a ceiling of 3; not-taken decrements to a floor of 0.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- Non-branch, invalid or flushed EX instruction: res_valid=0 next cycle; no table write.

## Timing
- Reset values:
  - all counters = 1 (weak-NT)
  - res_valid = 0, res_taken = 0, mispredict = 0
  - id_pred_taken therefore reads 0
- Reset mid-operation: the in-flight resolve is dropped; outputs are 0 on the cycle after reset is sampled.
- Resolve latency: 1 cycle. res_* and mispredict are valid on the edge after EX sampling and held for exactly one cycle.
- Table write takes effect at the same edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (read-before-write). The next cycle sees the new value.
- Back-to-back branches to the same index update sequentially; each cycle sees the previous write.
- No handshake or stall input. The stage controller gates ex_valid when EX stalls, so each instruction resolves exactly once.

## Configuration
- BRANCH_STATS_EN defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every res_valid cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both wrap modulo 2^32 and reset to 0.
- BRANCH_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package branch_pkg:
  - opcode constants OP_REGIMM=6'h01, OP_BEQ=6'h04, OP_BNE=6'h05, OP_BLEZ=6'h06, OP_BGTZ=6'h07
  - RT_BLTZ=5'd0, RT_BGEZ=5'd1
  - 2-bit counter typedef and state constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
- Sub-module branch_cond (combinational): takes opcode, rt, arg1 and arg2; outputs is_br and taken; parametrised by DATA_W.
- Top module: the BHT array, update logic, result registers and optional stats.

## Test plan
- Reset, then lookup at any PC: id_pred_taken=0 and all outputs 0. Issue BEQ arg1=arg2=5 with pred 0: next cycle res_valid=1, res_taken=1, mispredict=1.
- Signedness, DATA_W=32:
  - BGTZ arg1=32'h8000_0000, arg2=0 gives res_taken=0.
  - BLTZ same operands gives res_taken=1.
  - BGEZ arg1=0 gives res_taken=1.
  - BLEZ arg1=0 gives res_taken=1.
- Training: three taken BNE at PC 0x40 move the counter 1→2→3→3, so id_pred_taken at 0x40 reads 1 after the first update. Two not-taken updates then give 3→2→1, and the prediction reads 0.
- Aliasing and collision: PC 0x40 and 0x40+4·BHT_DEPTH share a counter. A same-cycle lookup and update at idx returns the old value; the following cycle returns the new one.
- Suppression:
  - opcode 6'h01 with rt=2, ex_flush=1 with a valid BEQ, or ex_valid=0: res_valid=0 and the counter is unchanged.
  - Reset asserted while a branch is in EX: outputs are 0 next cycle.
- With BRANCH_STATS_EN: 10 branches including 3 mispredicts give stat_branches=10 and stat_mispredicts=3. Preloading a counter at 32'hFFFF_FFFF then wraps to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared opcode constants and 2-bit counter helpers for the branch
// resolve/predict slice.
package branch_pkg;

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;

   localparam logic [4:0] RT_BLTZ = 5'd0;
   localparam logic [4:0] RT_BGEZ = 5'd1;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;

   // Saturating step toward the observed direction.
   function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
      ctr_t nxt;
      nxt = cur;
      if (taken && cur != CTR_ST) nxt = cur + 2'd1;
      else if (!taken && cur != CTR_SNT) nxt = cur - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch decode and signed condition evaluation.
module branch_cond
   import branch_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [5:0]        opcode,
   input  logic [4:0]        rt,
   input  logic [DATA_W-1:0] arg1,
   input  logic [DATA_W-1:0] arg2,
   output logic              is_br,
   output logic              taken
);

   logic eq, lt, gt;

   assign eq = (arg1 == arg2);
   assign lt = ($signed(arg1) < $signed(arg2));
   assign gt = ($signed(arg1) > $signed(arg2));

   always_comb begin
      is_br = 1'b0;
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  begin is_br = 1'b1; taken = eq;  end
         OP_BNE:  begin is_br = 1'b1; taken = !eq; end
         OP_BLEZ: begin is_br = 1'b1; taken = !gt; end
         OP_BGTZ: begin is_br = 1'b1; taken = gt;  end
         OP_REGIMM: begin
            if (rt == RT_BLTZ) begin
               is_br = 1'b1;
               taken = lt;
            end else if (rt == RT_BGEZ) begin
               is_br = 1'b1;
               taken = !lt;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolution with a bimodal 2-bit direction table read by ID.
// Optional BRANCH_STATS_EN adds branch / mispredict event counters.
module branch_resolve_predict
   import branch_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned BHT_DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   id_pc,
   output logic              id_pred_taken,
   input  logic              ex_valid,
   input  logic              ex_flush,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [5:0]        ex_opcode,
   input  logic [4:0]        ex_rt,
   input  logic [DATA_W-1:0] ex_arg1,
   input  logic [DATA_W-1:0] ex_arg2,
   input  logic              ex_pred_taken,
   output logic              res_valid,
   output logic              res_taken,
   output logic              mispredict
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
`endif
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   ctr_t             bht_q [BHT_DEPTH];
   logic [IDX_W-1:0] id_idx, ex_idx;
   logic             br_is, br_taken, resolve;
   logic             res_valid_q, res_taken_q, mispredict_q;

   assign id_idx = id_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Word-offset and upper PC bits do not take part in indexing.
   logic unused_pc;
   assign unused_pc = ^{id_pc[PC_W-1:IDX_W+2], id_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

   branch_cond #(
      .DATA_W (DATA_W)
   ) u_cond (
      .opcode (ex_opcode),
      .rt     (ex_rt),
      .arg1   (ex_arg1),
      .arg2   (ex_arg2),
      .is_br  (br_is),
      .taken  (br_taken)
   );

   assign resolve       = ex_valid & ~ex_flush & br_is;
   assign id_pred_taken = bht_q[id_idx][1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WNT;
         res_valid_q  <= 1'b0;
         res_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
      end else begin
         res_valid_q  <= resolve;
         res_taken_q  <= resolve & br_taken;
         mispredict_q <= resolve & (br_taken != ex_pred_taken);
         if (resolve) bht_q[ex_idx] <= ctr_next(bht_q[ex_idx], br_taken);
      end
   end

   assign res_valid  = res_valid_q;
   assign res_taken  = res_taken_q;
   assign mispredict = mispredict_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_q + {31'd0, res_valid_q};
         stat_mp_q <= stat_mp_q + {31'd0, mispredict_q};
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`endif

endmodule
